mem_responder: RTL

- Memory-side end of the CPU memory handshake: consumes memEN / RW / address (from MAR) / write data (from MDR) and returns read data plus the MFC (memory-function-complete) acknowledge.
- Sits between the MAR/MDR datapath registers and the word-addressed RAM array.
- Provides configurable wait-state latency so the initiator's MFC wait loops are exercised.

---
 rtl/mem_bus_pkg.sv | 8 +
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 83 ++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, RW codes and default widths for the memory responder
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory handshake bus (memEN, RW, addr, data_in -> data_out, MFC[, memErr])
// master = initiator (MAR/MDR side), slave = responder; memErr exists only with MEMRESP_BUSERR_EN
interface mem_responder_if import mem_bus_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic memEN;
  logic RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic MFC;
`ifdef MEMRESP_BUSERR_EN
  logic memErr;
  modport master (output memEN, RW, addr, data_in, input data_out, MFC, memErr);
  modport slave (input memEN, RW, addr, data_in, output data_out, MFC, memErr);
`else
  modport master (output memEN, RW, addr, data_in, input data_out, MFC);
  modport slave (input memEN, RW, addr, data_in, output data_out, MFC);
`endif
endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W storage, synchronous write, registered read
// Ports: clk, rst (sync, active-low, clears rdata only), we, re, clr (forces rdata to 0), addr, wdata, rdata
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 256,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic re,
  input  logic clr,
  input  logic [IW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  always_ff @(posedge clk)
    rdata <= (!rst || clr) ? '0 : re ? mem[addr] : rdata;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side MFC handshake responder with LATENCY wait states and address range check
// Ports: clk, rst (sync, active-low), bus (mem_responder_if.slave: memEN, RW, addr, data_in, data_out, MFC[, memErr])
// Optional: MEMRESP_BUSERR_EN adds memErr, raised with MFC for accesses at or beyond DEPTH
module mem_responder import mem_bus_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  mem_responder_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state;
  logic [3:0] cnt;
  logic rw_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] data_l;
  logic [DATA_W-1:0] rdata;
  logic mfc;
  logic in_range;
  logic fire;
  assign in_range = {1'b0, addr_l} < (ADDR_W + 1)'(DEPTH);
  // the completing edge; gated by rst so a reset on that edge cannot commit a write
  assign fire = rst && state == BUSY && bus.memEN && cnt == '0;
  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .rst(rst),
    .we(fire && rw_l == RW_WRITE && in_range),
    .re(fire && rw_l == RW_READ && in_range),
    .clr(fire && rw_l == RW_READ && !in_range),
    .addr(addr_l[IW-1:0]),
    .wdata(data_l),
    .rdata(rdata)
  );
  assign bus.data_out = rdata;
  assign bus.MFC = mfc;
`ifdef MEMRESP_BUSERR_EN
  logic err;
  assign bus.memErr = err;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      mfc <= 1'b0;
      rw_l <= RW_READ;
      addr_l <= '0;
      data_l <= '0;
`ifdef MEMRESP_BUSERR_EN
      err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.memEN) begin
          rw_l <= bus.RW;
          addr_l <= bus.addr;
          data_l <= bus.data_in;
          cnt <= 4'(LATENCY);
          state <= BUSY;
        end
        BUSY: if (!bus.memEN) state <= IDLE;
          else if (cnt != '0) cnt <= cnt - 4'd1;
          else begin
            mfc <= 1'b1;
`ifdef MEMRESP_BUSERR_EN
            err <= !in_range;
`endif
            state <= ACK;
          end
        ACK: if (!bus.memEN) begin
          mfc <= 1'b0;
`ifdef MEMRESP_BUSERR_EN
          err <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
